// File: rtl/bip_debug_unit.sv
// bip_debug_unit
// Run controller and result reporter for the BIP processor. Starts a program
// run by raising o_bip_valid, counts run cycles, detects the HALT opcode and
// then streams a 6-byte result frame (pc, acc, cycle count; MSB first) to a
// byte-wide UART transmitter over a valid/ready handshake.
//
// Ports:
//   i_clock        system clock
//   i_reset        asynchronous active-high reset
//   i_start        run request, honoured only while idle
//   i_instruction  instruction word presented by the BIP
//   i_pc           BIP program counter
//   i_acc          BIP accumulator
//   i_tx_ready     UART transmitter can accept a byte
//   o_bip_valid    enables the BIP to advance (high while running)
//   o_tx_data      current frame byte
//   o_tx_valid     o_tx_data is valid (high while sending)
//   o_busy         high while running or sending
module bip_debug_unit #(
  parameter int unsigned             NB_DATA            = 16,
  parameter int unsigned             NB_OPCODE          = 5,
  parameter int unsigned             LOG2_N_INSMEM_ADDR = 11,
  parameter int unsigned             NB_CYCLE_CNT       = 16,
  parameter logic [NB_OPCODE-1:0]    HALT_OPCODE        = '0,
  parameter int unsigned             HALT_MASK          = 2
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_start,
  input  logic [NB_DATA-1:0]            i_instruction,
  input  logic [LOG2_N_INSMEM_ADDR-1:0] i_pc,
  input  logic [NB_DATA-1:0]            i_acc,
  input  logic                          i_tx_ready,
  output logic                          o_bip_valid,
  output logic [7:0]                    o_tx_data,
  output logic                          o_tx_valid,
  output logic                          o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SEND = 2'd2
  } state_t;

  // The run index only needs to reach HALT_MASK; it saturates there so long
  // runs never wrap back into the masked window.
  localparam int unsigned NB_RUN_IDX = $clog2(HALT_MASK + 1) + 1;
  localparam logic [NB_RUN_IDX-1:0] MASK_LIM = NB_RUN_IDX'(HALT_MASK);

  state_t                  state;
  logic [NB_RUN_IDX-1:0]   run_idx;
  logic [NB_CYCLE_CNT-1:0] cycle_cnt;
  logic [2:0]              byte_idx;
  logic [15:0]             cap_pc;
  logic [NB_DATA-1:0]      cap_acc;
  logic [15:0]             cap_cnt;

  logic [NB_OPCODE-1:0]    opcode;
  logic                    past_mask;
  logic                    halt;
  logic [NB_CYCLE_CNT-1:0] cnt_inc;

  logic unused_instr_bits;
  assign unused_instr_bits = ^i_instruction[NB_DATA-NB_OPCODE-1:0];

  assign opcode    = i_instruction[NB_DATA-1 -: NB_OPCODE];
  assign past_mask = (run_idx >= MASK_LIM);
  assign halt      = (state == RUN) && past_mask && (opcode == HALT_OPCODE);

  // cycle_cnt holds completed RUN cycles; cnt_inc is the count including the
  // current cycle, saturating at all-ones.
  assign cnt_inc = (cycle_cnt == '1) ? cycle_cnt
                                     : cycle_cnt + NB_CYCLE_CNT'(1);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state     <= IDLE;
      run_idx   <= '0;
      cycle_cnt <= '0;
      byte_idx  <= '0;
      cap_pc    <= '0;
      cap_acc   <= '0;
      cap_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            state     <= RUN;
            run_idx   <= '0;
            cycle_cnt <= '0;
            byte_idx  <= '0;
          end
        end
        RUN: begin
          cycle_cnt <= cnt_inc;
          if (!past_mask) begin
            run_idx <= run_idx + NB_RUN_IDX'(1);
          end
          if (halt) begin
            cap_pc   <= 16'(i_pc);
            cap_acc  <= i_acc;
            cap_cnt  <= 16'(cnt_inc);
            byte_idx <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (i_tx_ready) begin
            if (byte_idx == 3'd5) begin
              byte_idx <= '0;
              state    <= IDLE;
            end else begin
              byte_idx <= byte_idx + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_bip_valid = (state == RUN);
  assign o_tx_valid  = (state == SEND);
  assign o_busy      = (state != IDLE);

  // Byte select from registered index and captures; forced to zero outside
  // SEND so the bus is quiet while idle.
  always_comb begin
    o_tx_data = '0;
    if (state == SEND) begin
      case (byte_idx)
        3'd0:    o_tx_data = cap_pc[15:8];
        3'd1:    o_tx_data = cap_pc[7:0];
        3'd2:    o_tx_data = cap_acc[15:8];
        3'd3:    o_tx_data = cap_acc[7:0];
        3'd4:    o_tx_data = cap_cnt[15:8];
        3'd5:    o_tx_data = cap_cnt[7:0];
        default: o_tx_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_bip_debug_unit.sv
module tb_bip_debug_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, s_start;
  logic [15:0] instr;
  logic [10:0] pc;
  logic [15:0] acc;
  logic        tx_ready;

  logic        bip_valid, tx_valid, busy;
  logic [7:0]  tx_data;
  logic        s_bip_valid, s_tx_valid, s_busy;
  logic [7:0]  s_tx_data;

  logic        sel;
  logic        m_bip, m_valid, m_busy;
  logic [7:0]  m_data;

  int          bp_mode;
  int          errors = 0;
  int          checks = 0;
  int          bip_cycles = 0;
  int          popped = 0;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  logic [7:0]  exp_q[$];
  chk_t        chk_q[$];

  always #5 clk = ~clk;

  bip_debug_unit dut (
    .i_clock(clk), .i_reset(rst), .i_start(start),
    .i_instruction(instr), .i_pc(pc), .i_acc(acc),
    .i_tx_ready(tx_ready), .o_bip_valid(bip_valid),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .o_busy(busy)
  );

  bip_debug_unit #(.NB_CYCLE_CNT(4)) dut_sat (
    .i_clock(clk), .i_reset(rst), .i_start(s_start),
    .i_instruction(instr), .i_pc(pc), .i_acc(acc),
    .i_tx_ready(tx_ready), .o_bip_valid(s_bip_valid),
    .o_tx_data(s_tx_data), .o_tx_valid(s_tx_valid), .o_busy(s_busy)
  );

  assign m_bip   = sel ? s_bip_valid : bip_valid;
  assign m_valid = sel ? s_tx_valid  : tx_valid;
  assign m_busy  = sel ? s_busy      : busy;
  assign m_data  = sel ? s_tx_data   : tx_data;

  // Monitor: owns all counters; pops expected bytes on each handshake and
  // evaluates check records posted by the stimulus.
  logic       have_prev = 1'b0;
  logic       prev_valid, prev_acc;
  logic [7:0] prev_data;

  always @(negedge clk) begin
    chk_t c;
    logic [7:0] e;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      checks++;
      if (c.act !== c.exp) begin
        errors++;
        $display("FAIL %s: got %0h want %0h", c.name, c.act, c.exp);
      end
    end
    if (!rst) begin
      if (m_bip) bip_cycles++;
      if (m_valid && have_prev && prev_valid && !prev_acc) begin
        checks++;
        if (m_data !== prev_data) begin
          errors++;
          $display("FAIL hold_stable: got %0h want %0h", m_data, prev_data);
        end
      end
      if (m_valid && tx_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_byte: got %0h want none", m_data);
        end else begin
          e = exp_q.pop_front();
          if (m_data !== e) begin
            errors++;
            $display("FAIL frame_byte: got %0h want %0h", m_data, e);
          end
        end
        popped++;
      end
      prev_valid = m_valid;
      prev_acc   = m_valid && tx_ready;
      prev_data  = m_data;
      have_prev  = 1'b1;
    end else begin
      have_prev = 1'b0;
    end
  end

  // Ready driver: mode 0 ties high, mode 1 cycles 1,0,0.
  initial begin
    int n;
    n = 0;
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode == 0) begin
        tx_ready = 1'b1;
      end else begin
        tx_ready = (n % 3 == 0);
        n++;
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    chk_t c;
    c.name = n;
    c.act  = a;
    c.exp  = e;
    chk_q.push_back(c);
  endtask

  task automatic run_prog(input bit use_sat, input int halt_idx, input bit all_zero,
                          input logic [10:0] hpc, input logic [15:0] hacc);
    int          cnt;
    logic [15:0] pc16;
    cnt = halt_idx + 1;
    if (use_sat && cnt > 15) cnt = 15;
    pc16 = {5'b0, hpc};
    exp_q.push_back(pc16[15:8]);
    exp_q.push_back(pc16[7:0]);
    exp_q.push_back(hacc[15:8]);
    exp_q.push_back(hacc[7:0]);
    exp_q.push_back(8'((cnt >> 8) & 8'hFF));
    exp_q.push_back(8'(cnt & 8'hFF));
    @(posedge clk); #1;
    if (use_sat) s_start = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    s_start = 1'b0;
    for (int idx = 0; idx <= halt_idx; idx++) begin
      if (all_zero || idx == halt_idx) instr = 16'h0000;
      else instr = 16'h8000 | 16'(idx);
      pc  = (idx == halt_idx) ? hpc  : 11'(idx + 100);
      acc = (idx == halt_idx) ? hacc : 16'hFFFF - 16'(idx);
      if (idx < halt_idx) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    instr = 16'hF800;
    pc    = 11'h7AA;
    acc   = 16'hDEAD;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk); #1;
      if (!m_busy) done = 1'b1;
    end
    if (!done) chk("busy_timeout", {31'b0, m_busy}, 32'd0);
  endtask

  initial begin
    int b0, p0;
    bit got;
    rst = 1'b1; start = 1'b0; s_start = 1'b0;
    instr = 16'hF800; pc = '0; acc = '0;
    bp_mode = 0; sel = 1'b0;
    #3;
    chk("reset_main", {21'b0, bip_valid, tx_valid, busy, tx_data}, 32'd0);
    chk("reset_sat", {21'b0, s_bip_valid, s_tx_valid, s_busy, s_tx_data}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Basic run: halt at index 10.
    b0 = bip_cycles;
    run_prog(1'b0, 10, 1'b0, 11'h00A, 16'h1234);
    wait_idle();
    chk("basic_bip_cycles", 32'(bip_cycles - b0), 32'd11);
    chk("basic_frame_done", 32'(exp_q.size()), 32'd0);

    // Masked HALT opcode in run indices 0-1.
    b0 = bip_cycles;
    run_prog(1'b0, 2, 1'b1, 11'h3C5, 16'hA5A5);
    wait_idle();
    chk("mask_bip_cycles", 32'(bip_cycles - b0), 32'd3);
    chk("mask_frame_done", 32'(exp_q.size()), 32'd0);

    // Backpressure.
    bp_mode = 1;
    run_prog(1'b0, 5, 1'b0, 11'h7FF, 16'h0F0E);
    wait_idle();
    chk("bp_frame_done", 32'(exp_q.size()), 32'd0);
    bp_mode = 0;

    // Start during SEND is ignored; reset after byte 2 abandons the frame.
    b0 = bip_cycles;
    p0 = popped;
    run_prog(1'b0, 4, 1'b0, 11'h155, 16'hBEEF);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_in_send", {30'b0, busy, bip_valid}, 32'd2);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk); #1;
      if (popped >= p0 + 3) got = 1'b1;
    end
    if (!got) chk("byte2_timeout", 32'(popped - p0), 32'd3);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("reset_mid_frame", {21'b0, bip_valid, tx_valid, busy, tx_data}, 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("reset_bip_cycles", 32'(bip_cycles - b0), 32'd5);
    run_prog(1'b0, 3, 1'b0, 11'h2AB, 16'h1357);
    wait_idle();
    chk("fresh_frame_done", 32'(exp_q.size()), 32'd0);

    // Saturating 4-bit counter.
    sel = 1'b1;
    b0 = bip_cycles;
    run_prog(1'b1, 19, 1'b0, 11'h0C3, 16'h8001);
    wait_idle();
    chk("sat_bip_cycles", 32'(bip_cycles - b0), 32'd20);
    chk("sat_frame_done", 32'(exp_q.size()), 32'd0);
    sel = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bip_debug_unit.md
# bip_debug_unit

Run controller and result reporter that sits downstream of the BIP processor top. It gates the processor's `i_valid` to start a program run and counts run cycles. It watches the processor's instruction, PC and accumulator outputs for the HALT opcode, freezes the final state, and streams it as a 6-byte frame to a byte-wide UART transmitter over a valid/ready handshake.

## Interface
Parameters:
- `NB_DATA`, 16, width of accumulator and instruction words
- `NB_OPCODE`, 5, opcode width; opcode is `i_instruction[NB_DATA-1 -: NB_OPCODE]`
- `LOG2_N_INSMEM_ADDR`, 11, PC width (must be ≤ 16)
- `NB_CYCLE_CNT`, 16, cycle counter width
- `HALT_OPCODE`, 5'b00000, opcode that ends a run
- `HALT_MASK`, 2, number of initial RUN cycles during which HALT detection is ignored (covers program-memory read latency and its reset value)

Ports:
- `i_clock`  in  1  system clock
- `i_reset`  in  1  asynchronous, active-high reset
- `i_start`  in  1  start request, sampled only in IDLE
- `i_instruction`  in  NB_DATA  instruction currently presented by the BIP
- `i_pc`  in  LOG2_N_INSMEM_ADDR  BIP program counter
- `i_acc`  in  NB_DATA  BIP accumulator
- `i_tx_ready`  in  1  UART TX can accept a byte
- `o_bip_valid`  out  1  drives BIP `i_valid`; processor advances only while high
- `o_tx_data`  out  8  frame byte
- `o_tx_valid`  out  1  `o_tx_data` is valid
- `o_busy`  out  1  high in RUN or SEND

## Operation
- States: IDLE, RUN, SEND.
- IDLE:
  - `o_bip_valid`=0, `o_tx_valid`=0.
  - `i_start`=1 → RUN next cycle; the cycle counter and run index clear to 0.
- RUN:
  - `o_bip_valid`=1.
  - The run index increments every cycle, starting at 0 in the first RUN cycle.
  - The cycle counter holds the number of RUN cycles elapsed, including the current one. It saturates at 2^NB_CYCLE_CNT−1 and does not wrap.
  - HALT is detected when the run index ≥ HALT_MASK and the opcode equals HALT_OPCODE.
  - On detection, in that same cycle:
    - capture `i_pc` zero-extended to 16 bits, `i_acc`, and the cycle counter (including the halt cycle);
    - go to SEND.
  - `o_bip_valid` drops in the next cycle.
- SEND:
  - Bytes go out in order: pc[15:8], pc[7:0], acc[15:8], acc[7:0], cnt[15:8], cnt[7:0]. Counts narrower than 16 bits are zero-extended; wider counts send only the low 16 bits.
  - `o_tx_valid`=1 throughout SEND.
  - A byte is accepted on any cycle with `o_tx_valid` & `i_tx_ready`; the byte index then advances.
  - `o_tx_data` holds stable until its byte is accepted.
  - Acceptance of byte 5 → IDLE next cycle.
- `i_start` is ignored outside IDLE.
- `i_instruction`, `i_pc` and `i_acc` are ignored outside RUN; captured values are frozen during SEND.
- Reset at any time, including mid-RUN or mid-frame:
  - immediately forces IDLE;
  - clears the counter, byte index and captured registers;
  - all outputs go to 0;
  - a partial frame is abandoned, not resumed.

## Timing
- Reset values: `o_bip_valid`=0, `o_tx_valid`=0, `o_tx_data`=0, `o_busy`=0.
- Start: `i_start` sampled high at edge N makes `o_bip_valid`=`o_busy`=1 from edge N onward (registered outputs).
- Halt: detection in cycle K makes `o_bip_valid`=0 and `o_tx_valid`=1 after edge K, with byte 0 on `o_tx_data`.
- With `i_tx_ready` tied high, one byte is accepted per cycle, so the frame takes 6 cycles. `o_busy` falls after the edge that accepts byte 5.
- `i_tx_ready` may toggle arbitrarily; no byte is skipped or duplicated.
- All state is registered; the only combinational path from input to output is none (`o_tx_data` is muxed from registered index and captures).

## Test plan
- **Reset values:** assert `i_reset` asynchronously between clock edges → all outputs 0 immediately; state IDLE.
- **Basic run:** pulse `i_start`; `i_instruction` opcode ≠ 0 for run indices 0..9, then opcode 0 with `i_pc`=0x00A and `i_acc`=0x1234; `i_tx_ready`=1.
  - Required: `o_bip_valid` high for exactly 11 cycles.
  - Required frame: 0x00 0x0A 0x12 0x34 0x00 0x0B.
- **Mask:** `i_instruction`=0x0000 from the first RUN cycle → no halt at run indices 0–1; halt at index 2.
  - Required: count byte pair 0x00 0x03; `o_bip_valid` high for 3 cycles.
- **Backpressure:** `i_tx_ready` alternates 1,0,0,1,… during SEND → the same 6 bytes in order; `o_tx_data` stable while ready=0; no duplicates.
- **Ignored start / reset mid-frame:** pulse `i_start` during SEND → no effect. Assert `i_reset` after byte 2 accepted → outputs 0 immediately. A new `i_start` then runs a fresh frame that begins with the pc[15:8] byte.
- **Saturation:** with NB_CYCLE_CNT=4, halt after 20 RUN cycles → count bytes 0x00 0x0F.
